// File: rtl/chunked_adder.sv
`timescale 1ns/1ps
// chunked_adder
//   Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock.
//   The carry ripples between chunks through a register. A start/busy/done
//   handshake sequences operations. Results and flags update together on the
//   final chunk edge, so partial results are never visible.
//
// Ports
//   clk       : clock, rising-edge active
//   rst       : asynchronous active-high reset
//   start     : request a new operation (sampled in IDLE or DONE only)
//   sub       : 0 = a + b + cin, 1 = a - b (cin ignored)
//   a, b      : WIDTH-bit operands, captured on the accepting edge
//   cin       : carry-in for add
//   busy      : high while chunks are being processed
//   done      : one-cycle pulse when sum/flags are valid
//   sum       : WIDTH-bit result, held until the next done
//   cout      : carry out of the MSB (NOT borrow when subtracting)
//   overflow  : signed overflow
//   zero      : sum == 0
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  // Operand and partial-result shift registers (data only, no reset).
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic [CHUNK:0]       csum;
  logic [WIDTH+CHUNK-1:0] res_shift;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;

    // Operands shift right each RUN cycle, so the active chunk is always
    // in the low CHUNK bits; results shift in from the top.
    csum      = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
              + (CHUNK+1)'(carry_q);
    res_shift = {csum[CHUNK-1:0], res_q};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = csum[CHUNK];
        res_d   = res_shift[WIDTH+CHUNK-1:CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          idx_d   = '0;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_d;
          cout_d  = csum[CHUNK];
          // Carry into the MSB is a^b^s at that bit; XOR with carry out.
          ovf_d   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ csum[CHUNK-1] ^ csum[CHUNK];
          zero_d  = (res_d == '0);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---- control and output registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // ---- datapath registers ----
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
`timescale 1ns/1ps
// Directed testbench for chunked_adder: three instances (8/1, 8/4, 32/8)
// share clock and reset and are exercised one after another.
module tb_chunked_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance 0: WIDTH=8, CHUNK=1
  logic st0, sb0, ci0, bz0, dn0, co0, ov0, zr0;
  logic [7:0] a0, b0, s0;
  // Instance 1: WIDTH=8, CHUNK=4
  logic st1, sb1, ci1, bz1, dn1, co1, ov1, zr1;
  logic [7:0] a1, b1, s1;
  // Instance 2: WIDTH=32, CHUNK=8
  logic st2, sb2, ci2, bz2, dn2, co2, ov2, zr2;
  logic [31:0] a2, b2, s2;

  chunked_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
    .clk(clk), .rst(rst), .start(st0), .sub(sb0), .a(a0), .b(b0), .cin(ci0),
    .busy(bz0), .done(dn0), .sum(s0), .cout(co0), .overflow(ov0), .zero(zr0));
  chunked_adder #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .clk(clk), .rst(rst), .start(st1), .sub(sb1), .a(a1), .b(b1), .cin(ci1),
    .busy(bz1), .done(dn1), .sum(s1), .cout(co1), .overflow(ov1), .zero(zr1));
  chunked_adder #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
    .clk(clk), .rst(rst), .start(st2), .sub(sb2), .a(a2), .b(b2), .cin(ci2),
    .busy(bz2), .done(dn2), .sum(s2), .cout(co2), .overflow(ov2), .zero(zr2));

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input int w, input logic s, input logic sb, input logic ci,
                       input logic [31:0] a, input logic [31:0] b);
    case (w)
      0: begin st0 = s; sb0 = sb; ci0 = ci; a0 = a[7:0]; b0 = b[7:0]; end
      1: begin st1 = s; sb1 = sb; ci1 = ci; a1 = a[7:0]; b1 = b[7:0]; end
      default: begin st2 = s; sb2 = sb; ci2 = ci; a2 = a; b2 = b; end
    endcase
  endtask

  task automatic get_obs(input int w, output logic bz, output logic dn,
                         output logic [31:0] s, output logic co,
                         output logic ov, output logic zr);
    case (w)
      0: begin bz = bz0; dn = dn0; s = {24'h0, s0}; co = co0; ov = ov0; zr = zr0; end
      1: begin bz = bz1; dn = dn1; s = {24'h0, s1}; co = co1; ov = ov1; zr = zr1; end
      default: begin bz = bz2; dn = dn2; s = s2; co = co2; ov = ov2; zr = zr2; end
    endcase
  endtask

  // One complete operation: start, scramble inputs after capture, measure
  // latency, then check result, flags and the end of the done pulse.
  task automatic run_op(input int w, input int n, input logic [31:0] a,
                        input logic [31:0] b, input logic ci, input logic sb,
                        input logic [31:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input string tag);
    logic bz, dn, co, ov, zr;
    logic [31:0] s;
    int lat;
    @(negedge clk);
    drive(w, 1'b1, sb, ci, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, ~sb, ~ci, ~a, ~b);
    get_obs(w, bz, dn, s, co, ov, zr);
    check({tag, "_busy"}, {31'b0, bz}, 32'd1);
    lat = 0;
    for (int k = 1; k <= n + 4 && lat == 0; k++) begin
      @(negedge clk);
      get_obs(w, bz, dn, s, co, ov, zr);
      if (dn) lat = k;
    end
    check({tag, "_latency"}, lat, n);
    if (lat != 0) begin
      check({tag, "_sum"}, s, exp_sum);
      check({tag, "_cout"}, {31'b0, co}, {31'b0, exp_cout});
      check({tag, "_ovf"}, {31'b0, ov}, {31'b0, exp_ovf});
      check({tag, "_zero"}, {31'b0, zr}, {31'b0, (exp_sum == 32'h0)});
      check({tag, "_busy_done"}, {31'b0, bz}, 32'd0);
    end
    @(negedge clk);
    get_obs(w, bz, dn, s, co, ov, zr);
    check({tag, "_done_drop"}, {31'b0, dn}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic bz, dn, co, ov, zr;
    logic [31:0] s;
    logic [31:0] exp_s [3];
    logic fa_a, fa_b, fa_c;

    rst = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    for (int w = 0; w < 3; w++) begin
      get_obs(w, bz, dn, s, co, ov, zr);
      check($sformatf("reset_outs_%0d", w), {s[28:0], bz, dn, co | ov | zr}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Full-adder truth table on bit 0, one bit per cycle
    for (int r = 0; r < 8; r++) begin
      fa_a = r[2]; fa_b = r[1]; fa_c = r[0];
      run_op(0, 8, {31'b0, fa_a}, {31'b0, fa_b}, fa_c, 1'b0,
             {30'b0, (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c), fa_a ^ fa_b ^ fa_c},
             1'b0, 1'b0, $sformatf("fa_row%0d", r));
    end

    // 8/4 directed vectors
    run_op(1, 2, 32'hF0, 32'h10, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, "add_f0_10");
    run_op(1, 2, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, "add_7f_01");
    run_op(1, 2, 32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0, "sub_05_07");
    run_op(1, 2, 32'h80, 32'h01, 1'b1, 1'b1, 32'h7F, 1'b1, 1'b1, "sub_80_01");

    // 32/8 back-to-back with start held and operands changed mid-RUN
    exp_s[0] = 32'hACF13569;  // 12345678 + 9ABCDEF0 + 1
    exp_s[1] = 32'hFFFFFFF0;  // 10 - 20
    exp_s[2] = 32'h80000000;  // 7FFFFFFF + 1
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_busy_k0", {31'b0, bz2}, 32'd1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("b2b_done_k%0d", k), {31'b0, dn2},
            {31'b0, (k == 4 || k == 9 || k == 14)});
      check($sformatf("b2b_busy_k%0d", k), {31'b0, bz2},
            {31'b0, !(k == 4 || k == 9 || k >= 14)});
      if (k == 4)  check("b2b_sum0", s2, exp_s[0]);
      if (k == 9)  check("b2b_sum1", s2, exp_s[1]);
      if (k == 14) begin
        check("b2b_sum2", s2, exp_s[2]);
        check("b2b_ovf2", {31'b0, ov2}, 32'd1);
      end
      if (k == 1)  drive(2, 1'b1, 1'b1, 1'b1, 32'h00000010, 32'h00000020);
      if (k == 6)  drive(2, 1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001);
      if (k == 11) drive(2, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0BADF00D);
      if (k == 14) drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Reset asserted mid-operation at idx=2
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 1'b0, 32'h0F0F0F0F, 32'h01010101);
    @(posedge clk);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_sum", s2, 32'h0);
    check("rst_mid_flags", {27'b0, bz2, dn2, co2, ov2, zr2}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_done_k%0d", k), {30'b0, dn2, bz2}, 32'h0);
    end
    run_op(2, 4, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "rst_next");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
